pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. It observes register addresses leaving Decode and in flight in Execute, Memory and Writeback, plus branch and memory-handshake status. It produces forwarding selects, per-stage stall and flush controls, and a multi-cycle memory-wait freeze with timeout. It sits beside the datapath, and its FlushE output drives the Decode/Execute pipeline register flush.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before fault (legal range 2..255)
- CNT_W, 16: width of the stall-cycle counter

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4  source registers of the instruction in Decode
- RA1E, RA2E  in  4  source registers of the instruction in Execute
- WA3E, WA3M, WA3W  in  4  destination registers in Execute, Memory and Writeback
- RegWriteM, RegWriteW  in  1  destination write enables in Memory and Writeback
- MemtoRegE  in  1  Execute instruction is a load
- PCWrPendingF  in  1  a PC-writing instruction is in Decode, Execute or Memory
- BranchTakenE  in  1  branch resolved taken in Execute
- MemAccessM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  bubble into the corresponding pipeline register
- MemFault  out  1  sticky memory-timeout indication
- StallCnt  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- FSM states: RUN, MEMWAIT, FAULT. Reset state is RUN.
- Wait counter wcnt (8 bit) counts consecutive not-ready memory cycles.
- memhold is 1 in RUN when MemAccessM & !MemReadyM, and 1 in MEMWAIT when !MemReadyM.
- Forwarding for operand A; B is identical using RA2E:
  - 10 if RegWriteM & WA3M==RA1E.
  - Otherwise 01 if RegWriteW & WA3W==RA1E.
  - Otherwise 00.
  - Always 00 when RA1E==4'hF, because R15 is sourced from PCPlus8.
- ldrstall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D) & !BranchTakenE.
- RUN with memhold=0:
  - StallF = ldrstall | PCWrPendingF.
  - StallD = ldrstall.
  - FlushD = PCWrPendingF | BranchTakenE.
  - FlushE = ldrstall | BranchTakenE.
  - StallE, StallM and FlushW are 0.
- RUN with memhold=1:
  - StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0.
  - Branch and load-use actions are deferred; they re-evaluate once the freeze ends.
  - Next state MEMWAIT, wcnt ← 1.
- MEMWAIT:
  - Outputs are identical to RUN with memhold=1 while !MemReadyM.
  - On MemReadyM: freeze is dropped that same cycle, outputs follow the RUN equations, next state RUN, wcnt ← 0.
  - On !MemReadyM with wcnt == MEM_TIMEOUT-1: next state FAULT. Otherwise wcnt increments.
- FAULT is terminal until reset:
  - StallF/D/E/M = 1, FlushW = 1, MemFault = 1.
  - All other flushes are 0 and forwarding selects are still computed.
- StallCnt increments on every cycle with StallF=1 and saturates at all-ones (no wrap).

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
- State, wcnt, MemFault and StallCnt update on the rising edge of clk.
- Reset values:
  - state RUN, wcnt 0, MemFault 0, StallCnt 0.
- While reset is low, outputs are forced regardless of inputs:
  - Stall* = 0, FlushD = FlushE = FlushW = 1, Forward* = 00.
- Reset asserted mid-MEMWAIT or in FAULT returns to RUN asynchronously. Reset has priority over everything.
- A memory access ready on its first cycle costs 0 stall cycles.
- An access ready on its N-th cycle (N ≤ MEM_TIMEOUT) costs N-1 freeze cycles.
- MEM_TIMEOUT consecutive not-ready cycles enter FAULT on the following edge.
- BranchTakenE together with a load-use match: the branch wins. There is no stall, and D and E are flushed.
- BranchTakenE together with memhold: the freeze wins, and the branch is acted on in the first unfrozen cycle.

## Test plan
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=4 -> ForwardAE=10, ForwardBE=00. With RA1E=15 -> ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle and StallCnt 0→1. Repeating with BranchTakenE=1 -> StallF=0, FlushD=FlushE=1.
- MemAccessM=1 with MemReadyM low for 3 cycles, then high -> StallF/D/E/M=FlushW=1 for exactly 3 cycles, state back to RUN, StallCnt +3, MemFault=0.
- MEM_TIMEOUT=4 with MemReadyM never asserted -> FAULT after 4 not-ready cycles; MemFault=1 and all stalls stay high for the 20 following cycles.
- Reset pulsed low during the 2nd MEMWAIT cycle -> immediate Stall*=0, FlushD/E/W=1, state RUN, StallCnt=0, MemFault=0.
- CNT_W=4 with StallF held high for 20 cycles -> StallCnt sticks at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the five-stage pipeline.
//   - Forwarding selects for the Execute operands (ForwardAE/ForwardBE).
//   - Load-use stall, branch/PC-write flushes.
//   - Multi-cycle data-memory freeze with timeout into a terminal FAULT state.
//   - Saturating count of fetch-stall cycles (StallCnt).
// Ports:
//   clk, reset (async, active-low)
//   RA1D/RA2D, RA1E/RA2E       source registers in Decode / Execute
//   WA3E/WA3M/WA3W             destination registers in Execute / Memory / Writeback
//   RegWriteM/W, MemtoRegE     write enables, load-in-Execute
//   PCWrPendingF, BranchTakenE PC-write pending, branch taken
//   MemAccessM, MemReadyM      data-memory handshake
//   ForwardAE/BE               00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E/M, FlushD/E/W   pipeline register controls
//   MemFault                   sticky memory timeout
//   StallCnt                   saturating StallF cycle count
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPendingF,
  input  logic             BranchTakenE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemFault,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;

  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             memhold;
  logic             ldrstall;

  // R15 reads PCPlus8, never a forwarded value.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic rwm,
                                         input logic [3:0] wam, input logic rww,
                                         input logic [3:0] waw);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (rwm && (wam == ra))      sel = 2'b10;
      else if (rww && (waw == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    memhold  = ((state_q == RUN) && MemAccessM && !MemReadyM) ||
               ((state_q == MEMWAIT) && !MemReadyM);
    ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D)) && !BranchTakenE;
  end

  // Outputs: reset override first, then FAULT, then freeze, then normal hazards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      if ((state_q == FAULT) || memhold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldrstall || PCWrPendingF;
        StallD = ldrstall;
        FlushD = PCWrPendingF || BranchTakenE;
        FlushE = ldrstall || BranchTakenE;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_fault_d = mem_fault_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (memhold) begin
          state_d = MEMWAIT;
          wcnt_d  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d     = FAULT;
          mem_fault_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_fault_q <= mem_fault_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemFault = mem_fault_q;
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share one stimulus stream:
// instance 0 uses default parameters, instance 1 uses MEM_TIMEOUT=4, CNT_W=4.
// A reference model (counts of not-ready cycles, fault flag, stall count)
// predicts every output each cycle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenE;
  logic       MemAccessM, MemReadyM;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, mf0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, mf1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  pipeline_hazard_ctrl u_dut0 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0),
    .FlushD(fd0), .FlushE(fe0), .FlushW(fw0),
    .MemFault(mf0), .StallCnt(sc0)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
    .FlushD(fd1), .FlushE(fe1), .FlushW(fw1),
    .MemFault(mf1), .StallCnt(sc1)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state per instance.
  int unsigned nr   [2];          // consecutive not-ready cycles of the current access
  bit          flt  [2];          // timeout reached
  int unsigned cnt  [2];          // StallF cycle count
  int unsigned tmo  [2] = '{16, 4};
  int unsigned cmax [2] = '{65535, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_inst(input int k);
    logic [1:0] efa, efb, gfa, gfb;
    logic [3:0] est, gst;
    logic [2:0] efl, gfl;
    logic       hold, ld, gmf;
    logic [31:0] gsc;
    string      p;
    p = (k == 0) ? "i0" : "i1";
    if (k == 0) begin
      gfa = fa0; gfb = fb0; gst = {sf0, sd0, se0, sm0}; gfl = {fd0, fe0, fw0};
      gmf = mf0; gsc = 32'(sc0);
    end else begin
      gfa = fa1; gfb = fb1; gst = {sf1, sd1, se1, sm1}; gfl = {fd1, fe1, fw1};
      gmf = mf1; gsc = 32'(sc1);
    end
    hold = 1'b0;
    if (!reset) begin
      nr[k] = 0; flt[k] = 1'b0; cnt[k] = 0;
      efa = 2'b00; efb = 2'b00; est = 4'b0000; efl = 3'b111;
    end else begin
      efa = ref_fwd(RA1E);
      efb = ref_fwd(RA2E);
      hold = !flt[k] && !MemReadyM && (nr[k] > 0 || MemAccessM);
      if (flt[k] || hold) begin
        est = 4'b1111; efl = 3'b001;
      end else begin
        ld  = MemtoRegE && (WA3E == RA1D || WA3E == RA2D) && !BranchTakenE;
        est = {ld | PCWrPendingF, ld, 2'b00};
        efl = {PCWrPendingF | BranchTakenE, ld | BranchTakenE, 1'b0};
      end
    end
    check({p, " ForwardAE"}, 32'(gfa), 32'(efa));
    check({p, " ForwardBE"}, 32'(gfb), 32'(efb));
    check({p, " StallFDEM"}, 32'(gst), 32'(est));
    check({p, " FlushDEW"},  32'(gfl), 32'(efl));
    check({p, " MemFault"},  32'(gmf), 32'(flt[k]));
    check({p, " StallCnt"},  gsc, cnt[k]);
    if (reset) begin
      if (!flt[k]) begin
        if (hold) begin
          nr[k]++;
          if (nr[k] == tmo[k]) flt[k] = 1'b1;
        end else begin
          nr[k] = 0;
        end
      end
      if (est[3] && cnt[k] < cmax[k]) cnt[k]++;
    end
  endtask

  // Check current inputs at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCWrPendingF = 1'b0; BranchTakenE = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b1;
  endtask

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 4) == 4) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  task automatic rnd_inputs();
    RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
    WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
    RegWriteM    = 1'($urandom_range(0, 1));
    RegWriteW    = 1'($urandom_range(0, 1));
    MemtoRegE    = ($urandom_range(0, 2) == 0);
    PCWrPendingF = ($urandom_range(0, 5) == 0);
    BranchTakenE = ($urandom_range(0, 5) == 0);
    MemAccessM   = ($urandom_range(0, 5) == 0);
    MemReadyM    = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    step();
    step();
    reset = 1'b1;
    idle();
    step();

    // Forwarding: M beats W; R15 never forwarded.
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    RA1E = 4'd3; RA2E = 4'd4;
    step();
    RA1E = 4'hF;
    step();

    // Load-use stall, then load-use together with a taken branch.
    idle();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    step();
    idle();
    step();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; BranchTakenE = 1'b1;
    step();

    // Access ready on its 4th cycle: three freeze cycles; branch held under freeze.
    idle();
    MemAccessM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1;
    repeat (3) step();
    MemReadyM = 1'b1;
    step();
    idle();
    step();

    // Timeout: instance 1 faults after 4 cycles, instance 0 after 16.
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    repeat (24) step();
    idle();
    repeat (4) step();
    do_reset();
    idle();
    step();

    // Reset during the 2nd MEMWAIT cycle.
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    step();

    // Stall counter saturation on the 4-bit instance.
    PCWrPendingF = 1'b1;
    repeat (20) step();
    idle();
    step();

    // Randomized traffic with occasional reset pulses.
    for (int unsigned i = 0; i < 2000; i++) begin
      rnd_inputs();
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        MemAccessM = 1'b1; MemReadyM = 1'b0;
        repeat ($urandom_range(1, 6)) begin
          step();
          rnd_inputs();
          MemReadyM = 1'b0;
        end
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
